fetch_unit: RTL and testbench

//  Instruction fetch stage of the RV32IM core. Generates the fetch PC and reads a

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: generates the fetch PC, reads a 1-cycle synchronous imem and
// presents one instruction/PC pair per cycle with a stall handshake and a one-entry skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 12,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               STALL,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  output logic               IMEM_EN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_RDATA,
  output logic [31:0]        INSTRUCTION,
  output logic [31:0]        PC,
  output logic               VALID,
  output logic               MISALIGN_ERR
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        adv;
  logic        issue;

  assign adv = ~valid_q | ~STALL;
  // A word still in flight while the output is stalled will occupy the skid, so stop issuing.
  assign issue = (state_q == RUN) & ~REDIRECT & ~skid_v_q & ~(inflight_q & valid_q & STALL);

  assign IMEM_EN      = issue;
  assign IMEM_ADDR    = fpc_q[IMEM_AW+1:2];
  assign INSTRUCTION  = instr_q;
  assign PC           = pc_q;
  assign VALID        = valid_q;
  assign MISALIGN_ERR = misalign_q;

  always_comb begin
    state_d       = state_q;
    fpc_d         = fpc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_v_d      = skid_v_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    misalign_d    = misalign_q;

    if (state_q == BOOT) begin
      state_d = RUN;
    end

    if (REDIRECT) begin
      inflight_d = 1'b0;
      skid_v_d   = 1'b0;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      fpc_d      = {REDIRECT_PC[31:2], 2'b00};
      if (REDIRECT_PC[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fpc_q;
        fpc_d         = fpc_q + 32'd4;
      end

      if (inflight_q) begin
        if (adv) begin
          instr_d = IMEM_RDATA;
          pc_d    = inflight_pc_q;
          valid_d = 1'b1;
        end else begin
          skid_instr_d = IMEM_RDATA;
          skid_pc_d    = inflight_pc_q;
          skid_v_d     = 1'b1;
        end
      end else if (adv) begin
        if (skid_v_q) begin
          instr_d  = skid_instr_q;
          pc_d     = skid_pc_q;
          valid_d  = 1'b1;
          skid_v_d = 1'b0;
        end else begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= BOOT;
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      skid_v_q      <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_q     <= 32'd0;
      instr_q       <= NOP_INSTR;
      pc_q          <= 32'd0;
      valid_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_v_q      <= skid_v_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected PCs is consumed whenever the DUT
// hands a word downstream; a second instance checks PC wrap-around from a high reset PC.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        STALL, REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_EN;
  logic [11:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION, PC;
  logic        VALID, MISALIGN_ERR;

  logic        b_en, b_valid, b_mis;
  logic [11:0] b_addr;
  logic [31:0] b_rdata, b_instr, b_pc;
  logic        b_zero = 1'b0;
  logic [31:0] b_zero32 = 32'd0;

  int checks = 0;
  int failures = 0;
  int consumed = 0;
  logic [31:0] sb_q[$];

  always #5 CLK = ~CLK;

  fetch_unit u_dut (
    .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_EN(IMEM_EN), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .INSTRUCTION(INSTRUCTION), .PC(PC), .VALID(VALID), .MISALIGN_ERR(MISALIGN_ERR)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .STALL(b_zero), .REDIRECT(b_zero), .REDIRECT_PC(b_zero32),
    .IMEM_EN(b_en), .IMEM_ADDR(b_addr), .IMEM_RDATA(b_rdata),
    .INSTRUCTION(b_instr), .PC(b_pc), .VALID(b_valid), .MISALIGN_ERR(b_mis)
  );

  // Memory model: word i holds i+100.
  always_ff @(posedge CLK) begin
    if (IMEM_EN) IMEM_RDATA <= {20'd0, IMEM_ADDR} + 32'd100;
    if (b_en)    b_rdata    <= {20'd0, b_addr} + 32'd100;
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {20'd0, pc[13:2]} + 32'd100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  // One clock: score a handed-off word before the edge, return at posedge+1.
  task automatic tick();
    logic [31:0] p;
    @(negedge CLK);
    if (VALID && !STALL && !REDIRECT) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed_pc=%h expected=<none>", PC);
      end
      if (sb_q.size() != 0) begin
        p = sb_q.pop_front();
        chk("sb_pc", PC, p);
        chk("sb_instr", INSTRUCTION, exp_instr(p));
      end
      consumed++;
    end
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] held_pc;
  int          base;

  initial begin
    RSTN = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_instr", INSTRUCTION, NOP);
    chk("rst_en", {31'd0, IMEM_EN}, 32'd0);
    chk("rst_mis", {31'd0, MISALIGN_ERR}, 32'd0);

    // 1: boot latency and streaming; second instance wraps past 2^32.
    RSTN = 1'b1;
    push_seq(32'd0, 64);
    tick();
    chk("boot_valid1", {31'd0, VALID}, 32'd0);
    #2;
    chk("boot_en", {31'd0, IMEM_EN}, 32'd1);
    chk("boot_addr", {20'd0, IMEM_ADDR}, 32'd0);
    tick();
    chk("boot_valid2", {31'd0, VALID}, 32'd0);
    tick();
    chk("boot_valid3", {31'd0, VALID}, 32'd1);
    chk("boot_pc", PC, 32'd0);
    chk("boot_instr", INSTRUCTION, 32'd100);
    chk("wrap_pc0", b_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", b_instr, 32'd100 + 32'hFFE);
    tick();
    chk("wrap_pc1", b_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", b_instr, 32'd100 + 32'hFFF);
    tick();
    chk("wrap_pc2", b_pc, 32'h0000_0000);
    chk("wrap_instr2", b_instr, 32'd100);
    chk("wrap_valid", {31'd0, b_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", {31'd0, VALID}, 32'd1);
    end

    // 2: stall three cycles mid-stream, then release.
    STALL = 1'b1;
    held_pc = PC;
    #2;
    chk("stall_en_now", {31'd0, IMEM_EN}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", PC, held_pc);
      chk("stall_valid", {31'd0, VALID}, 32'd1);
      #2;
      chk("stall_en", {31'd0, IMEM_EN}, 32'd0);
    end
    STALL = 1'b0;
    base = consumed;
    repeat (6) tick();
    checks++;
    assert (consumed - base >= 4) else begin
      failures++;
      $error("FAIL stall_resume observed=%0d expected>=4", consumed - base);
    end

    // 3: redirect while stalled with a full skid.
    STALL = 1'b1;
    repeat (2) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
    sb_q.delete();
    push_seq(32'h40, 32);
    tick();
    REDIRECT = 1'b0;
    chk("redir_valid0", {31'd0, VALID}, 32'd0);
    chk("redir_nop", INSTRUCTION, NOP);
    #2;
    chk("redir_en", {31'd0, IMEM_EN}, 32'd1);
    chk("redir_addr", {20'd0, IMEM_ADDR}, 32'h10);
    tick();
    chk("redir_valid1", {31'd0, VALID}, 32'd0);
    tick();
    chk("redir_valid2", {31'd0, VALID}, 32'd1);
    chk("redir_pc", PC, 32'h40);
    STALL = 1'b0;
    repeat (5) tick();
    chk("redir_mis", {31'd0, MISALIGN_ERR}, 32'd0);

    // 4: misaligned redirect target.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h42;
    sb_q.delete();
    push_seq(32'h40, 32);
    tick();
    REDIRECT = 1'b0;
    chk("mis_set", {31'd0, MISALIGN_ERR}, 32'd1);
    tick();
    tick();
    chk("mis_valid", {31'd0, VALID}, 32'd1);
    chk("mis_pc", PC, 32'h40);
    repeat (4) tick();
    chk("mis_sticky", {31'd0, MISALIGN_ERR}, 32'd1);

    // 6: reset pulse during a stall.
    STALL = 1'b1;
    repeat (2) tick();
    RSTN = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, IMEM_EN}, 32'd0);
    chk("mid_rst_valid", {31'd0, VALID}, 32'd0);
    chk("mid_rst_instr", INSTRUCTION, NOP);
    chk("mid_rst_mis", {31'd0, MISALIGN_ERR}, 32'd0);
    tick();
    RSTN = 1'b1; STALL = 1'b0;
    sb_q.delete();
    push_seq(32'd0, 32);
    tick();
    tick();
    chk("restart_valid2", {31'd0, VALID}, 32'd0);
    tick();
    chk("restart_valid3", {31'd0, VALID}, 32'd1);
    chk("restart_pc", PC, 32'd0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
